// File: rtl/led_cmd_pkg.sv
// Shared types and constants for the UART LED command front end.
package led_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_7 = 8'h37;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_c = 8'h63;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: rx synchronizer, framing FSM and shift register.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level on rx_s
// START     | timing to mid start bit; high there means a glitch
// DATA      | sampling 8 data bits LSB first, one per bit period
// STOP      | waiting for the stop-bit sample point
// WAIT_HIGH | stop bit was low (framing error/break), wait for line high
module uart_rx_byte
  import led_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            rx_m, rx_s;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            dv_d, fe_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_valid <= dv_d;
      frame_err  <= fe_d;
    end
  end

  // Counter is held at zero while waiting on the line so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data = shift_q;

endmodule

// File: rtl/uart_led_cmd.sv
// UART command front end: decodes received ASCII bytes into the LED cmd register.
module uart_led_cmd
  import led_cmd_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [2:0] cmd,
  output logic       cmd_stb,
  output logic       cmd_err,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_led_cmd: CLK_FREQ/BAUD must be at least 4");
  end

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       is_digit, is_clear;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (rx_data),
    .data_valid (rx_valid),
    .frame_err  (rx_frame_err)
  );

  always_comb begin
    is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_7);
    is_clear = (rx_data == ASCII_C) || (rx_data == ASCII_c);
  end

  // frame_err is re-registered so all three pulses share the same latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd       <= 3'd0;
      cmd_stb   <= 1'b0;
      cmd_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_stb   <= 1'b0;
      cmd_err   <= 1'b0;
      frame_err <= rx_frame_err;
      if (rx_valid) begin
        if (is_digit) begin
          cmd     <= rx_data[2:0];
          cmd_stb <= 1'b1;
        end else if (is_clear) begin
          cmd     <= 3'd0;
          cmd_stb <= 1'b1;
        end else begin
          cmd_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_led_cmd.sv
// Self-checking bench for uart_led_cmd: per-cycle compare against a latency-based frame model.
module tb_uart_led_cmd;

  localparam int CPB  = 16;
  localparam int LAT  = 155;
  localparam int MAXC = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [2:0] cmd;
  logic       cmd_stb, cmd_err, frame_err;

  uart_led_cmd #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .cmd       (cmd),
    .cmd_stb   (cmd_stb),
    .cmd_err   (cmd_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         exp_stb  [MAXC];
  bit         exp_cerr [MAXC];
  bit         exp_ferr [MAXC];
  logic [2:0] exp_val  [MAXC];

  int         total = 0;
  int         bad = 0;
  logic [2:0] model_cmd = 3'd0;
  int         stb_cnt = 0, cerr_cnt = 0, ferr_cnt = 0, last_stb_cyc = 0;
  bit         done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", name, cyc, act, req);
    end
  endtask

  // Expected outcome of a frame is fixed by the byte, the stop bit and a constant latency.
  function automatic void schedule(input int fall, input logic [7:0] b, input bit stop_ok);
    int t;
    t = fall + LAT;
    if (t >= MAXC) return;
    if (!stop_ok) exp_ferr[t] = 1'b1;
    else if (b >= 8'h30 && b <= 8'h37) begin
      exp_stb[t] = 1'b1;
      exp_val[t] = b[2:0];
    end else if (b == 8'h43 || b == 8'h63) begin
      exp_stb[t] = 1'b1;
      exp_val[t] = 3'd0;
    end else exp_cerr[t] = 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (reset) begin
        model_cmd = 3'd0;
        chk("cmd_rst", {29'd0, cmd}, 32'd0);
        chk("stb_rst", {31'd0, cmd_stb}, 32'd0);
        chk("cerr_rst", {31'd0, cmd_err}, 32'd0);
        chk("ferr_rst", {31'd0, frame_err}, 32'd0);
      end else if (cyc < MAXC) begin
        if (exp_stb[cyc]) model_cmd = exp_val[cyc];
        chk("cmd", {29'd0, cmd}, {29'd0, model_cmd});
        chk("cmd_stb", {31'd0, cmd_stb}, {31'd0, exp_stb[cyc]});
        chk("cmd_err", {31'd0, cmd_err}, {31'd0, exp_cerr[cyc]});
        chk("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr[cyc]});
      end
      if (cmd_stb === 1'b1) begin
        stb_cnt++;
        last_stb_cyc = cyc;
      end
      if (cmd_err === 1'b1) cerr_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called and returns on a negedge; abort_bit >= 0 pulses reset mid data bit.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int abort_bit, output int fall);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    fall = cyc + 1;
    if (abort_bit < 0) schedule(fall, b, stop_ok);
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        idle(CPB / 2);
        reset = 1'b1;
        rx = 1'b1;
        idle(3);
        reset = 1'b0;
        return;
      end
      idle(CPB);
    end
  endtask

  int f, f1, s0, stb1, c0, fe0, p0;
  logic [7:0] b;
  bit ok;

  initial begin
    @(negedge clk);
    idle(4);
    chk("reset_cmd", {29'd0, cmd}, 32'd0);
    reset = 1'b0;

    idle(200);
    chk("idle_pulses", stb_cnt + cerr_cnt + ferr_cnt, 0);
    chk("idle_cmd", {29'd0, cmd}, 32'd0);

    send(8'h35, 1'b1, -1, f);
    chk("lat_5", last_stb_cyc - f, 155);
    chk("cmd_5", {29'd0, cmd}, 32'd5);

    s0 = stb_cnt;
    send(8'h37, 1'b1, -1, f1);
    stb1 = last_stb_cyc;
    chk("cmd_7", {29'd0, cmd}, 32'd7);
    send(8'h63, 1'b1, -1, f);
    chk("b2b_gap", last_stb_cyc - stb1, 160);
    chk("b2b_cnt", stb_cnt - s0, 2);
    chk("cmd_c", {29'd0, cmd}, 32'd0);

    send(8'h35, 1'b1, -1, f);
    c0 = cerr_cnt;
    send(8'h41, 1'b1, -1, f);
    chk("cerr_A", cerr_cnt - c0, 1);
    chk("cmd_keep_A", {29'd0, cmd}, 32'd5);

    fe0 = ferr_cnt;
    send(8'h32, 1'b0, -1, f);
    idle(40);
    rx = 1'b1;
    idle(5);
    chk("ferr_cnt", ferr_cnt - fe0, 1);
    chk("cmd_keep_fe", {29'd0, cmd}, 32'd5);
    send(8'h31, 1'b1, -1, f);
    chk("cmd_1", {29'd0, cmd}, 32'd1);

    p0 = stb_cnt + cerr_cnt + ferr_cnt;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(30);
    chk("glitch_pulses", stb_cnt + cerr_cnt + ferr_cnt, p0);
    send(8'h33, 1'b1, -1, f);
    chk("cmd_3_after_glitch", {29'd0, cmd}, 32'd3);

    s0 = stb_cnt;
    send(8'h36, 1'b1, 4, f);
    idle(200);
    chk("abort_cmd", {29'd0, cmd}, 32'd0);
    chk("abort_stb", stb_cnt, s0);

    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0: b = 8'h30 + 8'($urandom_range(0, 7));
        1: b = ($urandom_range(0, 1) != 0) ? 8'h43 : 8'h63;
        default: b = 8'($urandom_range(0, 255));
      endcase
      ok = ($urandom_range(0, 5) != 0);
      send(b, ok, -1, f);
      if (!ok) begin
        idle($urandom_range(0, 40));
        rx = 1'b1;
        idle(4);
      end
      idle($urandom_range(0, 20));
    end

    idle(200);
    done = 1'b1;
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_led_cmd.md
# uart_led_cmd

Serial command front end for the LED controller. Receives 8N1 UART bytes on a single `rx` line, decodes ASCII commands, and drives the controller's 3-bit `cmd` input. A received digit `'0'`–`'7'` selects an LED pattern, and `'c'`/`'C'` clears it. The controller consumes `cmd` directly: nonzero overrides its blink pattern, zero returns it to blinking.

## Interface
Parameters:
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD`, 9600: UART bit rate.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD` (localparam): must be ≥ 4. Elaboration fails otherwise.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous UART line, idle high.
- `cmd`  out  3  current LED command, held until replaced or cleared.
- `cmd_stb`  out  1  one-cycle pulse when `cmd` is written, including writes of an unchanged value.
- `cmd_err`  out  1  one-cycle pulse when a valid frame carries an unrecognised byte.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized `rx_s`.
- Receiver FSM states:
  - IDLE: on `rx_s`==0, go to START and clear the bit counter.
  - START: at count `CLKS_PER_BIT/2 - 1`, sample `rx_s`. If 0, go to DATA and restart the counter. If 1, treat it as a glitch and return to IDLE.
  - DATA: every `CLKS_PER_BIT` cycles, sample one bit, LSB first, into the shift register. After 8 bits, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample the stop bit. If 1, the byte is valid and the FSM returns to IDLE. If 0, pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This covers break conditions.
- Decode of a valid byte `b`:
  - 0x30–0x37: `cmd <= b[2:0]`, pulse `cmd_stb`.
  - 0x43 or 0x63: `cmd <= 0`, pulse `cmd_stb`.
  - Any other value: `cmd` is unchanged; pulse `cmd_err`.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. It is reset at every state transition and never wraps inside a state.
- Exactly one of `cmd_stb`, `cmd_err`, `frame_err` pulses per completed frame. None pulses for a glitch rejected in START.

## Timing
- Reset values: `cmd`=0, `cmd_stb`=0, `cmd_err`=0, `frame_err`=0, FSM in IDLE, synchronizer flops at 1.
- Reset asserted mid-frame aborts the frame on the next edge. No pulse is emitted, and a partial byte never reaches `cmd`.
- Latency: the `cmd` update and its pulse are registered on the clock edge after the stop-bit sample. From the `rx` falling edge, this is 2 (sync) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles.
- `cmd_stb` is coincident with the new `cmd` value. The downstream controller sees the new `cmd` one cycle later.
- Back-to-back frames: the start bit may begin in the cycle after the stop-bit sample. The FSM returns to IDLE in time to detect it.
- A new falling edge during STOP, before the sample point, is ignored. Only the stop-bit sample decides the frame.

## Structure
- Package `led_cmd_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - ASCII constants: `ASCII_0`=0x30, `ASCII_7`=0x37, `ASCII_C`=0x43, `ASCII_c`=0x63.
  - Function `clks_per_bit(clk_freq, baud)`.
- One natural sub-module, `uart_rx_byte`, containing the synchronizer, FSM and shift register. Its outputs are `data[7:0]`, `data_valid` (1-cycle pulse) and `frame_err`.
- The top level holds the decode logic and the `cmd` register only.

## Test plan
Sim parameters: `CLK_FREQ`=16, `BAUD`=1, so `CLKS_PER_BIT`=16.
- Reset, then idle `rx`=1 for 200 cycles -> `cmd`=0 and no pulses.
- Send 0x35 (`'5'`) -> `cmd`=3'b101 with one `cmd_stb` exactly 2+8+144+1 = 155 cycles after the falling edge.
- Send `'7'` then `'c'` back-to-back -> `cmd`=7 then `cmd`=0, two `cmd_stb` pulses 160 cycles apart.
- Send 0x41 (`'A'`) while `cmd`=5 -> `cmd_err` pulses once and `cmd` stays 5.
- Send 0x32 with the stop bit forced low, hold `rx`=0 for 40 cycles, then release -> `frame_err` pulses once, `cmd` is unchanged, and the next `'1'` decodes to `cmd`=1.
- 5-cycle low glitch on `rx` -> no pulses, FSM back in IDLE. Assert `reset` during DATA of `'6'` -> `cmd`=0 and no `cmd_stb`.
